// File: rtl/led_sequence_monitor.sv
// led_sequence_monitor: checks the 0-2-3-5-0 LED count protocol on z, counts completed sequences, flags violations.
// Define LEDMON_RESYNC_EN to let the tracker leave ERR on a z=0 sample; otherwise ERR holds until reset.
module led_sequence_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic [2:0]       z,
    output logic             x_rec,
    output logic             done,
    output logic [CNT_W-1:0] seq_cnt,
    output logic             err,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        ST2  = 3'b001,
        ST3  = 3'b011,
        ST5  = 3'b010,
        ERR  = 3'b100
    } state_t;

    state_t cur, nxt;

    always_comb begin
        nxt = ERR;
        case (cur)
            IDLE:    nxt = (z == 3'd0) ? IDLE : (z == 3'd2) ? ST2 : ERR;
            ST2:     nxt = (z == 3'd0) ? IDLE : (z == 3'd3) ? ST3 : ERR;
            ST3:     nxt = (z == 3'd0) ? IDLE : (z == 3'd5) ? ST5 : ERR;
            ST5:     nxt = (z == 3'd0) ? IDLE : ERR;
`ifdef LEDMON_RESYNC_EN
            ERR:     nxt = (z == 3'd0) ? IDLE : ERR;
`else
            ERR:     nxt = ERR;
`endif
            default: nxt = ERR;
        endcase
    end

    // ST5 is only reachable from ST3, so entering it marks exactly one completion
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            cur     <= IDLE;
            x_rec   <= 1'b0;
            done    <= 1'b0;
            seq_cnt <= '0;
            err     <= 1'b0;
        end else begin
            cur     <= nxt;
            x_rec   <= (nxt == ST2) || (nxt == ST3) || (nxt == ST5);
            done    <= (nxt == ST5);
            seq_cnt <= ((nxt == ST5) && (seq_cnt != {CNT_W{1'b1}})) ? seq_cnt + 1'b1 : seq_cnt;
            err     <= err | (nxt == ERR);
        end
    end

    assign state = cur;
endmodule

// File: doc/led_sequence_monitor.md
# led_sequence_monitor

Receiving-end checker for the 3-bit LED-count bus `z` driven by the LED controller. The controller steps `z` through 0 → 2 → 3 → 5 → 0 while its request input is held. The monitor samples `z` every clock and does four things: reconstructs the producer's request, counts completed light sequences, flags protocol violations, and exposes its tracking state. It sits beside the controller in the top level, on the same clock, as an on-chip protocol monitor.

## Interface
Parameters:
- `CNT_W`, default 8: width of the completed-sequence counter.

Ports:
- `clock`, in, 1: single clock; all sampling on the rising edge.
- `reset_`, in, 1: asynchronous, active-high reset. The port keeps the codebase name; polarity is high-true.
- `z`, in, 3: LED count from the controller, sampled each rising edge.
- `x_rec`, out, 1: reconstructed request. 1 when the sampled `z` is a legal advance (2, 3 or 5).
- `done`, out, 1: one-cycle pulse when a legal 5 is accepted.
- `seq_cnt`, out, `CNT_W`: number of completed sequences, saturating.
- `err`, out, 1: sticky protocol-violation flag.
- `state`, out, 3: tracker state code.

## Operation
- The tracker state records the last accepted `z`. Encodings:
  - IDLE = 3'b000 (last 0)
  - ST2 = 3'b001 (last 2)
  - ST3 = 3'b011 (last 3)
  - ST5 = 3'b010 (last 5)
  - ERR = 3'b100
- Legal next-sample transitions:
  - IDLE: z=0 → IDLE; z=2 → ST2.
  - ST2: z=0 → IDLE (abort); z=3 → ST3.
  - ST3: z=0 → IDLE (abort); z=5 → ST5.
  - ST5: z=0 → IDLE. Any other value, including 5 again, is illegal.
- Values 1, 4, 6 and 7 are always illegal. Any sample outside the legal set for the current state → ERR, and `err` is set to 1.
- `x_rec` = 1 on entering ST2, ST3 or ST5; 0 on entering IDLE or ERR.
- `done` = 1 for exactly one cycle on entering ST5. On that same edge `seq_cnt` increments, saturating at 2^CNT_W−1.
- Aborts (a return to 0 before reaching 5) do not count as completions and do not set `err`.
- `err` is never cleared except by reset.
- ERR behaviour depends on `LEDMON_RESYNC_EN` (see Configuration).

## Timing
- All outputs are registered. Each output reflects the `z` sampled at the same rising edge, so latency is 1 edge from the sample point. The controller updates `z` shortly after its clock edge, so the monitor sees the value on the following edge.
- Reset values: `state`=IDLE, `x_rec`=0, `done`=0, `seq_cnt`=0, `err`=0.
- Reset asserted at any time, including mid-sequence or in ERR, forces these values immediately, without waiting for a clock edge.
- After reset deasserts, the first rising edge samples normally.
- The illegal-value check, `done` and `seq_cnt` updates are all evaluated in the same edge. An illegal sample never increments `seq_cnt`.

## Configuration
- `LEDMON_RESYNC_EN` undefined:
  - ERR is terminal until reset.
  - In ERR, `x_rec`=0 and `done`=0, and `seq_cnt` is frozen regardless of `z`.
- `LEDMON_RESYNC_EN` defined:
  - In ERR, a sample of z=0 → IDLE; any other sample stays in ERR.
  - Tracking and counting then resume normally.
  - `err` remains 1 (sticky) in both builds.

## Test plan
- Reset held 3 cycles, release, z=0 for 10 cycles → `state`=000, `x_rec`=0, `done`=0, `seq_cnt`=0, `err`=0 throughout.
- z=0,2,3,5,0 on successive edges → `x_rec` 1,1,1 then 0; `done` high only at the edge sampling 5; `seq_cnt`=1; `err`=0.
- Abort z=0,2,3,0,2,0 → `state` returns to IDLE twice; `seq_cnt`=0; `err`=0.
- Illegal z=0,3 → `err`=1 and `state`=100 at the edge sampling 3. Then drive z=0,2,3,5:
  - Without macro: `state` stays 100 and `seq_cnt`=0.
  - With macro: IDLE at the 0, `seq_cnt`=1 after the 5, `err` still 1.
- ST5 followed by z=5, and separately ST5 followed by z=2 → ERR in both cases. With `CNT_W`=2 and 5 full sequences → `seq_cnt` saturates at 3.
- Assert reset between edges while in ST3 → all outputs return to reset values before the next edge; `state`=IDLE.
